pu_cbus_master: RTL and testbench



---
 rtl/pu_cbus_master_if.sv | 25 ++
 rtl/pu_cbus_master.sv | 140 ++++++++++++++
 tb/tb_pu_cbus_master.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pu_cbus_master_if.sv
// rtl/pu_cbus_master_if.sv - cache-bus signal bundle between the pu bus master and the cache bus
interface pu_cbus_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
);
  logic              cbus_req;
  logic              cbus_grt;
  logic [1:0]        cbus_cmd;
  logic [ADDR_W-1:0] cbus_addr;
  logic [BE_W-1:0]   cbus_wr_data_be;
  logic [DATA_W-1:0] cbus_wr_data;
  logic              cbus_rdy;
  logic [DATA_W-1:0] cbus_rd_data;

  modport master (
    output cbus_req, cbus_cmd, cbus_addr, cbus_wr_data_be, cbus_wr_data,
    input  cbus_grt, cbus_rdy, cbus_rd_data
  );

  modport slave (
    input  cbus_req, cbus_cmd, cbus_addr, cbus_wr_data_be, cbus_wr_data,
    output cbus_grt, cbus_rdy, cbus_rd_data
  );
endinterface

// File: rtl/pu_cbus_master.sv
// rtl/pu_cbus_master.sv - processor-side cache-bus master: burst line fill, non-cached read, byte-enabled write
module pu_cbus_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BE_W      = DATA_W / 8,
  parameter int BURST_LEN = 4,
  parameter int BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  input  logic              req,
  input  logic              we,
  input  logic              nc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  output logic              ack,
  output logic              rd_valid,
  output logic [BEAT_W-1:0] rd_beat,
  output logic [DATA_W-1:0] rd_data,
  pu_cbus_master_if.master  cbus
);

  localparam logic [1:0] CMD_NO = 2'd0;
  localparam logic [1:0] CMD_RD = 2'd1;
  localparam logic [1:0] CMD_RN = 2'd2;
  localparam logic [1:0] CMD_WR = 2'd3;

  // Byte offset bits inside one cache line; cleared for line-fill addresses.
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BURST_LEN * BE_W - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  state_t            state;
  logic              l_we;
  logic              l_nc;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wr_data;
  logic [BE_W-1:0]   l_wr_be;
  logic [BEAT_W-1:0] beat_cnt;
  logic              last_beat;

  // Busy covers the request cycle itself so the core sees it before the bus is requested.
  assign busy = (state == IDLE && req) || (state != IDLE);

  // Only line fills need more than one beat; the issued command is the registered bus command.
  assign last_beat = (cbus.cbus_cmd != CMD_RD) || (beat_cnt == LAST_BEAT);

  // Transaction sequencer: latch request, arbitrate, collect beats, then release the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      l_we                 <= 1'b0;
      l_nc                 <= 1'b0;
      l_addr               <= '0;
      l_wr_data            <= '0;
      l_wr_be              <= '0;
      beat_cnt             <= '0;
      ack                  <= 1'b0;
      rd_valid             <= 1'b0;
      rd_beat              <= '0;
      rd_data              <= '0;
      cbus.cbus_req        <= 1'b0;
      cbus.cbus_cmd        <= CMD_NO;
      cbus.cbus_addr       <= '0;
      cbus.cbus_wr_data_be <= '0;
      cbus.cbus_wr_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            l_we          <= we;
            l_nc          <= nc;
            l_addr        <= addr;
            l_wr_data     <= wr_data;
            l_wr_be       <= wr_be;
            cbus.cbus_req <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (cbus.cbus_grt) begin
            if (l_we) begin
              cbus.cbus_cmd        <= CMD_WR;
              cbus.cbus_addr       <= l_addr;
              cbus.cbus_wr_data    <= l_wr_data;
              cbus.cbus_wr_data_be <= l_wr_be;
            end else if (l_nc) begin
              cbus.cbus_cmd        <= CMD_RN;
              cbus.cbus_addr       <= l_addr;
              cbus.cbus_wr_data    <= '0;
              cbus.cbus_wr_data_be <= '0;
            end else begin
              cbus.cbus_cmd        <= CMD_RD;
              cbus.cbus_addr       <= l_addr & ~LINE_MASK;
              cbus.cbus_wr_data    <= '0;
              cbus.cbus_wr_data_be <= '0;
            end
            state <= XFER;
          end
        end
        XFER: begin
          if (cbus.cbus_rdy) begin
            if (cbus.cbus_cmd != CMD_WR) begin
              rd_valid <= 1'b1;
              rd_data  <= cbus.cbus_rd_data;
              rd_beat  <= beat_cnt;
            end else begin
              rd_valid <= 1'b0;
            end
            if (last_beat) begin
              ack      <= 1'b1;
              beat_cnt <= '0;
              state    <= DONE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end else begin
            rd_valid <= 1'b0;
          end
        end
        DONE: begin
          cbus.cbus_req        <= 1'b0;
          cbus.cbus_cmd        <= CMD_NO;
          cbus.cbus_addr       <= '0;
          cbus.cbus_wr_data    <= '0;
          cbus.cbus_wr_data_be <= '0;
          ack                  <= 1'b0;
          rd_valid             <= 1'b0;
          rd_data              <= '0;
          state                <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pu_cbus_master.sv
// tb/tb_pu_cbus_master.sv - randomized self-checking bench for pu_cbus_master
module tb_pu_cbus_master;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BE_W      = 4;
  localparam int BURST_LEN = 4;
  localparam int BEAT_W    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic        req;
  logic        we;
  logic        nc;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        ack;
  logic        rd_valid;
  logic [1:0]  rd_beat;
  logic [31:0] rd_data;

  pu_cbus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) bus ();

  pu_cbus_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .BURST_LEN(BURST_LEN), .BEAT_W(BEAT_W)
  ) dut (
    .clk(clk), .rst(rst), .busy(busy), .req(req), .we(we), .nc(nc), .addr(addr),
    .wr_data(wr_data), .wr_be(wr_be), .ack(ack), .rd_valid(rd_valid), .rd_beat(rd_beat),
    .rd_data(rd_data), .cbus(bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // stimulus knobs filled by each test before a transaction
  bit          rdy_q[$];
  logic [31:0] data_src[$];

  // observations gathered by the bus responder
  logic [1:0]  o_cmd;
  logic [31:0] o_addr;
  logic [31:0] o_wd;
  logic [3:0]  o_be;
  int          unstable, busy_bad, nogrant_bad;
  int          req_cyc, grt_cyc, cmd_cyc, last_rdy_cyc, ack_n, ack_cyc, rel_cyc, rst_obs;
  int          ack_cycs[$];
  bit          ack_valid, rst_zero, timeout;
  logic [1:0]  ack_beat;
  logic [31:0] obs_data[$];
  logic [31:0] drv_data[$];
  int          obs_beat[$];
  int          exp_beat[$];

  // reference model of the command rules
  function automatic logic [1:0] m_cmd(bit w, bit n);
    return w ? 2'd3 : (n ? 2'd2 : 2'd1);
  endfunction

  function automatic logic [31:0] m_addr(bit w, bit n, logic [31:0] a);
    if (w || n) return a;
    return a - 32'(a % (BURST_LEN * BE_W));
  endfunction

  function automatic int m_need(bit w, bit n);
    return (w || n) ? 1 : BURST_LEN;
  endfunction

  // Issues one request (or n_txn back-to-back ones) and plays the cache-bus slave.
  task automatic do_txn(input bit t_we, input bit t_nc, input logic [31:0] t_addr,
                        input logic [31:0] t_wd, input logic [3:0] t_be, input int gdelay,
                        input bit toggle, input int n_txn, input int rst_beat);
    int n, bd, wait_n, need;
    bit done, rst_done, r;
    o_cmd = 0; o_addr = 0; o_wd = 0; o_be = 0;
    unstable = 0; busy_bad = 0; nogrant_bad = 0;
    req_cyc = -1; grt_cyc = -1; cmd_cyc = -1; last_rdy_cyc = -1;
    ack_n = 0; ack_cyc = -1; rel_cyc = -1; rst_obs = -1;
    ack_valid = 0; ack_beat = 0; rst_zero = 0; timeout = 0;
    ack_cycs.delete(); obs_data.delete(); drv_data.delete(); obs_beat.delete(); exp_beat.delete();
    need = m_need(t_we, t_nc);
    req = 1'b1; we = t_we; nc = t_nc; addr = t_addr; wr_data = t_wd; wr_be = t_be;
    bus.cbus_grt = 1'b0; bus.cbus_rdy = 1'b0;
    #1;
    if (busy !== 1'b1) busy_bad++;
    n = 0; bd = 0; wait_n = 0; done = 0; rst_done = 0;
    while (!done && n < 300) begin
      @(posedge clk); #1; n++;
      if (!rst_done && ack_n < n_txn && busy !== 1'b1) busy_bad++;
      if (bus.cbus_req === 1'b1 && req_cyc < 0) req_cyc = n;
      if (bus.cbus_cmd !== 2'd0) begin
        if (cmd_cyc < 0) begin
          cmd_cyc = n; o_cmd = bus.cbus_cmd; o_addr = bus.cbus_addr;
          o_wd = bus.cbus_wr_data; o_be = bus.cbus_wr_data_be;
        end else if ({bus.cbus_cmd, bus.cbus_addr, bus.cbus_wr_data, bus.cbus_wr_data_be}
                     !== {o_cmd, o_addr, o_wd, o_be}) begin
          unstable++;
        end
      end else if (cmd_cyc < 0 && !rst_done && bus.cbus_req !== 1'b1) begin
        nogrant_bad++;
      end
      if (rd_valid === 1'b1) begin
        obs_data.push_back(rd_data);
        obs_beat.push_back(int'(rd_beat));
      end
      if (ack === 1'b1) begin
        ack_n++; ack_cyc = n; ack_valid = rd_valid; ack_beat = rd_beat; ack_cycs.push_back(n);
      end
      if (rst_done && n == rst_obs + 1) begin
        rst_zero = ({bus.cbus_req, bus.cbus_cmd, bus.cbus_addr, bus.cbus_wr_data_be, bus.cbus_wr_data,
                     ack, rd_valid, rd_beat, rd_data, busy} === '0);
        rst = 1'b0;
      end
      if (rst_beat >= 0) begin
        if (rst_done && n == rst_obs + 3) done = 1;
      end else if (ack_n == n_txn && bus.cbus_req === 1'b0) begin
        rel_cyc = n; done = 1;
      end
      if (!done) begin
        req = (n_txn > 1 && ack_n < n_txn) ? 1'b1 : 1'b0;
        if (toggle) begin
          we = 1'($urandom); nc = 1'($urandom); addr = $urandom; wr_data = $urandom;
          wr_be = 4'($urandom);
        end
        if (rst_beat >= 0 && !rst_done && obs_data.size() == rst_beat + 1) begin
          rst = 1'b1; rst_done = 1; rst_obs = n;
        end
        bus.cbus_grt = 1'b0;
        if (bus.cbus_req === 1'b1 && bus.cbus_cmd === 2'd0) begin
          wait_n++;
          if (wait_n > gdelay) begin
            bus.cbus_grt = 1'b1;
            if (grt_cyc < 0) grt_cyc = n;
          end
        end else begin
          wait_n = 0;
        end
        if (bus.cbus_cmd !== 2'd0) begin
          bus.cbus_rdy = 1'b0;
          if (bd < need) begin
            r = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
            if (r) begin
              bus.cbus_rdy = 1'b1;
              bus.cbus_rd_data = (data_src.size() > 0) ? data_src.pop_front() : $urandom;
              if (!t_we) begin
                drv_data.push_back(bus.cbus_rd_data);
                exp_beat.push_back(bd % BURST_LEN);
              end
              bd++;
              if (bd == need) last_rdy_cyc = n;
            end
          end
        end else begin
          bd = 0;
          bus.cbus_rdy = 1'($urandom);
          bus.cbus_rd_data = $urandom;
        end
      end
    end
    timeout = !done;
    req = 1'b0; bus.cbus_grt = 1'b0; bus.cbus_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; we = 0; nc = 0; addr = 0; wr_data = 0; wr_be = 0;
    bus.cbus_grt = 1'b0; bus.cbus_rdy = 1'b0; bus.cbus_rd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.cbus_req, bus.cbus_cmd, bus.cbus_addr, bus.cbus_wr_data_be, bus.cbus_wr_data,
         ack, rd_valid, rd_beat, rd_data, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got req=%b cmd=%0d addr=%h ack=%b rd_valid=%b busy=%b, expected all 0",
               bus.cbus_req, bus.cbus_cmd, bus.cbus_addr, ack, rd_valid, busy);
    end
    rst = 1'b0; req = 1'b1; #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL busy_idle_req: got %b expected 1", busy);
    end
    req = 1'b0; #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL busy_idle_noreq: got %b expected 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cached_read();
    rdy_q.delete();
    data_src = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_txn(1'b0, 1'b0, 32'h0000_1034, 32'h0, 4'h0, 2, 1'b0, 1, -1);
    vectors++;
    if (timeout || o_cmd !== 2'd1 || o_addr !== 32'h0000_1030) begin
      miscompares++;
      $display("FAIL cached_cmd_addr: got timeout=%b cmd=%0d addr=%h expected 0/1/00001030", timeout, o_cmd, o_addr);
    end
    vectors++;
    if (obs_data.size() != 4) begin
      miscompares++; $display("FAIL cached_beats: got %0d beats expected 4", obs_data.size());
    end
    for (int i = 0; i < obs_data.size() && i < 4; i++) begin
      vectors++;
      if (obs_data[i] !== 32'hA0 + 32'(i) || obs_beat[i] != i) begin
        miscompares++;
        $display("FAIL cached_beat%0d: got data=%h beat=%0d expected %h/%0d", i, obs_data[i], obs_beat[i], 32'hA0 + 32'(i), i);
      end
    end
    vectors++;
    if (ack_n != 1 || !ack_valid || ack_beat !== 2'd3) begin
      miscompares++;
      $display("FAIL cached_ack: got acks=%0d with_valid=%b beat=%0d expected 1/1/3", ack_n, ack_valid, ack_beat);
    end
    vectors++;
    if (rel_cyc != ack_cyc + 1 || cmd_cyc != grt_cyc + 1) begin
      miscompares++;
      $display("FAIL cached_timing: got rel=%0d ack=%0d cmd=%0d grt=%0d expected rel=ack+1 cmd=grt+1", rel_cyc, ack_cyc, cmd_cyc, grt_cyc);
    end
  endtask

  task automatic test_noncached_read();
    rdy_q.delete();
    data_src = '{32'hDEAD_BEEF};
    do_txn(1'b0, 1'b1, 32'h8000_0004, 32'h0, 4'h0, 1, 1'b0, 1, -1);
    vectors++;
    if (timeout || o_cmd !== 2'd2 || o_addr !== 32'h8000_0004) begin
      miscompares++;
      $display("FAIL nc_cmd_addr: got timeout=%b cmd=%0d addr=%h expected 0/2/80000004", timeout, o_cmd, o_addr);
    end
    vectors++;
    if (obs_data.size() != 1 || obs_data[0] !== 32'hDEAD_BEEF || !ack_valid || ack_n != 1) begin
      miscompares++;
      $display("FAIL nc_data: got beats=%0d acks=%0d ack_with_valid=%b expected 1 beat DEADBEEF with ack", obs_data.size(), ack_n, ack_valid);
    end
  endtask

  task automatic test_write();
    rdy_q = '{1'b0, 1'b0, 1'b1};
    data_src.delete();
    do_txn(1'b1, 1'b1, 32'h0000_0200, 32'h1122_3344, 4'b0110, 0, 1'b0, 1, -1);
    vectors++;
    if (timeout || o_cmd !== 2'd3 || o_addr !== 32'h200 || o_wd !== 32'h1122_3344 || o_be !== 4'b0110) begin
      miscompares++;
      $display("FAIL write_bus: got timeout=%b cmd=%0d addr=%h data=%h be=%b expected 0/3/200/11223344/0110", timeout, o_cmd, o_addr, o_wd, o_be);
    end
    vectors++;
    if (obs_data.size() != 0 || ack_n != 1 || ack_cyc != last_rdy_cyc + 1) begin
      miscompares++;
      $display("FAIL write_ack: got rd_valids=%0d acks=%0d ack=%0d rdy=%0d expected 0/1/rdy+1", obs_data.size(), ack_n, ack_cyc, last_rdy_cyc);
    end
  endtask

  task automatic test_rdy_gaps();
    rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    data_src.delete();
    do_txn(1'b0, 1'b0, 32'h0000_4ABC, 32'h0, 4'h0, 1, 1'b1, 1, -1);
    vectors++;
    if (timeout || obs_data.size() != 4 || ack_n != 1 || unstable != 0) begin
      miscompares++;
      $display("FAIL gaps_summary: got timeout=%b beats=%0d acks=%0d unstable=%0d expected 0/4/1/0", timeout, obs_data.size(), ack_n, unstable);
    end
    for (int i = 0; i < obs_data.size() && i < drv_data.size(); i++) begin
      vectors++;
      if (obs_data[i] !== drv_data[i] || obs_beat[i] != exp_beat[i]) begin
        miscompares++;
        $display("FAIL gaps_beat%0d: got %h/%0d expected %h/%0d", i, obs_data[i], obs_beat[i], drv_data[i], exp_beat[i]);
      end
    end
    vectors++;
    if (o_addr !== 32'h0000_4AB0 || ack_cyc != last_rdy_cyc + 1) begin
      miscompares++;
      $display("FAIL gaps_addr_ack: got addr=%h ack=%0d rdy=%0d expected 00004ab0 rdy+1", o_addr, ack_cyc, last_rdy_cyc);
    end
  endtask

  task automatic test_reset_mid();
    rdy_q.delete(); data_src.delete();
    do_txn(1'b0, 1'b0, 32'h0000_0F00, 32'h0, 4'h0, 0, 1'b0, 1, 1);
    vectors++;
    if (!rst_zero || ack_n != 0 || obs_data.size() != 2) begin
      miscompares++;
      $display("FAIL reset_mid: got zero_after_reset=%b acks=%0d beats=%0d expected 1/0/2", rst_zero, ack_n, obs_data.size());
    end
    do_txn(1'b0, 1'b0, 32'h0000_0F14, 32'h0, 4'h0, 0, 1'b0, 1, -1);
    vectors++;
    if (timeout || ack_n != 1 || obs_data.size() != 4 || o_addr !== 32'h0000_0F10) begin
      miscompares++;
      $display("FAIL reset_recover: got timeout=%b acks=%0d beats=%0d addr=%h expected 0/1/4/00000f10", timeout, ack_n, obs_data.size(), o_addr);
    end
  endtask

  task automatic test_back_to_back();
    rdy_q.delete(); data_src.delete();
    do_txn(1'b0, 1'b1, 32'h0000_0044, 32'h0, 4'h0, 0, 1'b0, 2, -1);
    vectors++;
    if (timeout || ack_cycs.size() != 2) begin
      miscompares++; $display("FAIL b2b_acks: got timeout=%b acks=%0d expected 0/2", timeout, ack_cycs.size());
    end else begin
      vectors++;
      if (ack_cycs[0] != 3 || ack_cycs[1] - ack_cycs[0] != 4) begin
        miscompares++;
        $display("FAIL b2b_period: got first=%0d second=%0d expected 3 and 7", ack_cycs[0], ack_cycs[1]);
      end
    end
    vectors++;
    if (busy_bad != 0 || obs_data.size() != 2) begin
      miscompares++; $display("FAIL b2b_busy: got busy_low=%0d beats=%0d expected 0/2", busy_bad, obs_data.size());
    end
  endtask

  task automatic test_no_grant();
    rdy_q.delete(); data_src.delete();
    do_txn(1'b1, 1'b0, 32'h0000_0010, 32'hCAFE_0001, 4'b1111, 20, 1'b0, 1, -1);
    vectors++;
    if (timeout || nogrant_bad != 0 || busy_bad != 0) begin
      miscompares++;
      $display("FAIL nogrant_hold: got timeout=%b bad_cycles=%0d busy_low=%0d expected 0/0/0", timeout, nogrant_bad, busy_bad);
    end
    vectors++;
    if (cmd_cyc != 22 || ack_n != 1) begin
      miscompares++; $display("FAIL nogrant_cmd: got cmd_cycle=%0d acks=%0d expected 22/1", cmd_cyc, ack_n);
    end
  endtask

  task automatic test_random();
    bit w, n;
    logic [31:0] a, d;
    logic [3:0] b;
    int gd, need, glen;
    for (int it = 0; it < 40; it++) begin
      w = 1'($urandom); n = 1'($urandom); a = $urandom; d = $urandom; b = 4'($urandom);
      gd = $urandom_range(0, 3);
      rdy_q.delete(); data_src.delete();
      glen = $urandom_range(0, 6);
      for (int k = 0; k < glen; k++) rdy_q.push_back(1'($urandom));
      need = m_need(w, n);
      do_txn(w, n, a, d, b, gd, 1'b1, 1, -1);
      vectors++;
      if (timeout || o_cmd !== m_cmd(w, n) || o_addr !== m_addr(w, n, a)) begin
        miscompares++;
        $display("FAIL rnd%0d_cmd: got timeout=%b cmd=%0d addr=%h expected 0/%0d/%h", it, timeout, o_cmd, o_addr, m_cmd(w, n), m_addr(w, n, a));
      end
      vectors++;
      if ({o_wd, o_be} !== (w ? {d, b} : 36'd0)) begin
        miscompares++;
        $display("FAIL rnd%0d_wdata: got %h/%b expected %h/%b", it, o_wd, o_be, w ? d : 32'd0, w ? b : 4'd0);
      end
      vectors++;
      if (obs_data.size() != (w ? 0 : need)) begin
        miscompares++; $display("FAIL rnd%0d_beats: got %0d expected %0d", it, obs_data.size(), w ? 0 : need);
      end
      for (int i = 0; i < obs_data.size() && i < drv_data.size(); i++) begin
        vectors++;
        if (obs_data[i] !== drv_data[i] || obs_beat[i] != exp_beat[i]) begin
          miscompares++;
          $display("FAIL rnd%0d_beat%0d: got %h/%0d expected %h/%0d", it, i, obs_data[i], obs_beat[i], drv_data[i], exp_beat[i]);
        end
      end
      vectors++;
      if (ack_n != 1 || ack_cyc != last_rdy_cyc + 1 || ack_valid != !w ||
          (!w && ack_beat !== 2'(need - 1))) begin
        miscompares++;
        $display("FAIL rnd%0d_ack: got acks=%0d ack=%0d rdy=%0d valid=%b beat=%0d expected 1/rdy+1/%b/%0d", it, ack_n, ack_cyc, last_rdy_cyc, ack_valid, ack_beat, !w, need - 1);
      end
      vectors++;
      if (rel_cyc != ack_cyc + 1 || cmd_cyc != grt_cyc + 1 || req_cyc != 1) begin
        miscompares++;
        $display("FAIL rnd%0d_latency: got req=%0d grt=%0d cmd=%0d ack=%0d rel=%0d", it, req_cyc, grt_cyc, cmd_cyc, ack_cyc, rel_cyc);
      end
      vectors++;
      if (unstable != 0 || busy_bad != 0 || nogrant_bad != 0) begin
        miscompares++;
        $display("FAIL rnd%0d_stable: got unstable=%0d busy_low=%0d req_drop=%0d expected 0/0/0", it, unstable, busy_bad, nogrant_bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cached_read();
    test_noncached_read();
    test_write();
    test_rdy_gaps();
    test_reset_mid();
    test_back_to_back();
    test_no_grant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
